// File: rtl/ring_decoder_if.sv
// ring_decoder_if: sample and result bundle for ring_decoder.
// The master side drives the ring samples and the sample strobe. The slave
// side (the decoder) returns position, lock status, error pulse and lap count.
interface ring_decoder_if #(
   parameter int LAP_W = 8
);
   logic [3:0]       ring_in;
   logic             in_en;
   logic [1:0]       idx;
   logic             locked;
   logic             err;
   logic [LAP_W-1:0] lap_count;

   modport master (
      output ring_in,
      output in_en,
      input  idx,
      input  locked,
      input  err,
      input  lap_count
   );

   modport slave (
      input  ring_in,
      input  in_en,
      output idx,
      output locked,
      output err,
      output lap_count
   );
endinterface

// File: rtl/ring_decoder.sv
// ring_decoder: tracks a right-rotating 4-bit one-hot ring counter.
// The decoder hunts for LOCK_CNT consecutive legal rotations
// (1000->0100->0010->0001->1000). Once locked, it reports the binary position
// of the active bit. Any break in the sequence drops lock with a one-cycle err
// pulse, and a repeated sample counts as a break, so a stalled ring is caught.
// All outputs are registered and reflect the sample taken at the previous edge.
// Optional feature: define RING_DECODER_LAP_CNT_EN to count completed laps
// (0001->1000 while locked). Without it, lap_count is tied to zero and no
// counter register exists.
module ring_decoder #(
   parameter int LOCK_CNT = 2,
   parameter int LAP_W    = 8
) (
   input logic            clk,
   input logic            rst,
   ring_decoder_if.slave  bus
);

   localparam int STREAK_W = 4;

   typedef enum logic {
      ST_HUNT,
      ST_LOCKED
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          prev_q, prev_d;
   logic                prev_vld_q, prev_vld_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic [1:0]          idx_q, idx_d;
   logic                locked_q, locked_d;
   logic                err_q, err_d;

   logic                sample_onehot;
   logic [3:0]          succ_pattern;
   logic                is_succ;
   logic [1:0]          sample_pos;
   logic [STREAK_W-1:0] streak_inc;
   logic                streak_done;

   // Classify the incoming sample against the last accepted pattern.
   // is_succ requires a valid history. A valid prev is always one-hot, so its
   // rotation is one-hot too, and an equal sample is legal by construction.
   always_comb begin
      sample_onehot = (bus.ring_in != 4'b0000) &&
                      ((bus.ring_in & (bus.ring_in - 4'd1)) == 4'b0000);
      succ_pattern  = {prev_q[0], prev_q[3:1]};
      is_succ       = prev_vld_q && (bus.ring_in == succ_pattern);
      streak_inc    = streak_q + 4'd1;
      streak_done   = (streak_inc == STREAK_W'(LOCK_CNT));
   end

   // Map the one-hot sample to its binary position (bit 3 is position 0).
   always_comb begin
      sample_pos = 2'd0;
      case (bus.ring_in)
         4'b1000: sample_pos = 2'd0;
         4'b0100: sample_pos = 2'd1;
         4'b0010: sample_pos = 2'd2;
         4'b0001: sample_pos = 2'd3;
         default: sample_pos = 2'd0;
      endcase
   end

   // Next-state logic for the hunt/lock FSM and its tracking registers.
   // With in_en low, every register holds its value and err stays low.
   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
      streak_d   = streak_q;
      idx_d      = idx_q;
      locked_d   = locked_q;
      err_d      = 1'b0;

      if (bus.in_en) begin
         case (state_q)
            ST_HUNT: begin
               if (!sample_onehot) begin
                  streak_d   = '0;
                  prev_vld_d = 1'b0;
               end else if (is_succ) begin
                  prev_d   = bus.ring_in;
                  streak_d = streak_inc;
                  if (streak_done) begin
                     state_d  = ST_LOCKED;
                     locked_d = 1'b1;
                     idx_d    = sample_pos;
                  end
               end else begin
                  streak_d   = '0;
                  prev_d     = bus.ring_in;
                  prev_vld_d = 1'b1;
               end
            end

            ST_LOCKED: begin
               if (is_succ) begin
                  prev_d = bus.ring_in;
                  idx_d  = sample_pos;
               end else begin
                  err_d      = 1'b1;
                  locked_d   = 1'b0;
                  idx_d      = 2'd0;
                  state_d    = ST_HUNT;
                  streak_d   = '0;
                  prev_d     = bus.ring_in;
                  prev_vld_d = sample_onehot;
               end
            end

            default: begin
               state_d    = ST_HUNT;
               locked_d   = 1'b0;
               idx_d      = 2'd0;
               streak_d   = '0;
               prev_vld_d = 1'b0;
            end
         endcase
      end
   end

   // State register. Synchronous reset wins over any sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_HUNT;
         prev_q     <= 4'b0000;
         prev_vld_q <= 1'b0;
         streak_q   <= '0;
         idx_q      <= 2'd0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
         streak_q   <= streak_d;
         idx_q      <= idx_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
      end
   end

   assign bus.idx    = idx_q;
   assign bus.locked = locked_q;
   assign bus.err    = err_q;

`ifdef RING_DECODER_LAP_CNT_EN
   logic [LAP_W-1:0] lap_q, lap_d;
   logic             lap_inc;

   // A lap completes on a legal 0001->1000 rotation while locked. The count
   // wraps naturally and survives loss of lock.
   always_comb begin
      lap_inc = bus.in_en && (state_q == ST_LOCKED) && is_succ &&
                (prev_q == 4'b0001);
      lap_d   = lap_q;
      if (lap_inc) begin
         lap_d = lap_q + 1'b1;
      end
   end

   // Lap counter register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         lap_q <= '0;
      end else begin
         lap_q <= lap_d;
      end
   end

   assign bus.lap_count = lap_q;
`else
   assign bus.lap_count = {LAP_W{1'b0}};
`endif

endmodule

// File: doc/ring_decoder.md
RING_DECODER -- requirements
Module: ring_decoder

Interface
REQ-001 Parameter LOCK_CNT, default 2, meaning consecutive legal rotations needed to lock (range 1-15).
REQ-002 Parameter LAP_W, default 8, meaning lap counter width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 ring_in  input  4  one-hot ring pattern from a right-rotating ring counter.
REQ-006 in_en  input  1  sample strobe; ring_in is evaluated only when in_en=1.
REQ-007 idx  output  2  binary position of the current ring bit; registered.
REQ-008 locked  output  1  high while the decoder tracks a legal rotation sequence; registered.
REQ-009 err  output  1  one-cycle pulse on loss of lock; registered.
REQ-010 lap_count  output  LAP_W  number of completed rotations while locked; registered.

Function
REQ-011 Legal successor of pattern p SHALL be {p[0], p[3:1]}: 1000->0100->0010->0001->1000.
REQ-012 A sample SHALL be one-hot only if exactly one bit of ring_in is set; 0000 and multi-bit values are illegal.
REQ-013 Position mapping SHALL be 1000->0, 0100->1, 0010->2, 0001->3.
REQ-014 Internal state SHALL be: FSM state HUNT/LOCKED, prev[3:0], prev_vld, streak counter.
REQ-015 The in_en=0 condition SHALL leave all state unchanged, and err SHALL be 0 in that cycle.
REQ-016 In HUNT with in_en=1 and a non-one-hot sample, the block SHALL clear streak and prev_vld.
REQ-017 In HUNT with a one-hot sample and either prev_vld=0 or a sample that is not the successor of prev, the block SHALL set streak=0, prev=ring_in and prev_vld=1.
REQ-018 In HUNT with a sample equal to the successor of prev, the block SHALL set prev=ring_in and increment streak.
REQ-019 The HUNT->LOCKED transition SHALL occur when the incremented streak equals LOCK_CNT; on that edge, locked SHALL go to 1 and idx SHALL take the sample's position.
REQ-020 While in HUNT, idx SHALL be 0 and locked SHALL be 0.
REQ-021 In LOCKED with a sample equal to the successor of prev, the block SHALL update prev and idx.
REQ-022 In LOCKED, a legal 0001->1000 transition SHALL increment lap_count, wrapping from 2^LAP_W-1 to 0.
REQ-023 In LOCKED, any other sample (illegal or wrong successor) SHALL produce, on the next edge:
- err=1 for exactly one cycle
- locked=0, idx=0, state HUNT, streak=0
- prev=ring_in with prev_vld=1 if the sample is one-hot, otherwise prev_vld=0
REQ-024 A repeated identical sample is not a successor, so it SHALL break lock (stall detection).
REQ-025 Latency SHALL be 1 clock: all outputs reflect the sample taken at the preceding edge.
REQ-026 lap_count SHALL hold its value across loss of lock; it is cleared only by reset.

Reset
REQ-027 With rst=1 at a rising edge, the block SHALL set state=HUNT, prev=0000, prev_vld=0, streak=0, idx=0, locked=0, err=0 and lap_count=0.
REQ-028 rst SHALL take priority over in_en and ring_in, including mid-rotation while locked.

Configuration
REQ-029 Macro RING_DECODER_LAP_CNT_EN defined: lap_count SHALL behave per REQ-022 and REQ-026.
REQ-030 Macro RING_DECODER_LAP_CNT_EN undefined: no lap counter register SHALL exist, lap_count SHALL be constant 0, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset, then with in_en=1 drive 1000,0100,0010: locked=1 and idx=2 one cycle after the 0010 sample; locked=0 before that.
REQ-032 Locked, drive 0001,1000 repeatedly for 3 laps: lap_count=3 (macro defined) or 0 (undefined); idx follows 3,0,1,2,3,0.
REQ-033 Locked at 0100, drive 0001 (skip): err=1 for one cycle, locked=0, idx=0; then 1000,0100 relocks with LOCK_CNT=2.
REQ-034 Locked, drive 0110 then 0000: single err pulse, then HUNT with prev_vld=0; next 0010,0001,1000 relocks.
REQ-035 Locked, toggle in_en=0 for 5 cycles with garbage on ring_in: no output changes; resuming the legal sequence keeps lock.
REQ-036 LAP_W=2 with macro defined: 5 laps give lap_count=1; assert rst while locked, and the next cycle shows locked=0, lap_count=0.
